// File: rtl/cpu_selftest_checker.sv
// cpu_selftest_checker: on-chip self-test monitor for the CPU + MEM top level.
// Waits for CPU halt, checks the halt PC, then compares memory words to a table.
module cpu_selftest_checker #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int PC_W       = 9,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 4096,
  parameter logic [PC_W-1:0] HALT_PC = 'h00F,
  // entry i lives at bits [i*(ADDR_W+DATA_W) +: ADDR_W+DATA_W] as {addr, data}
  parameter logic [((NUM_CHECKS == 0) ? 1 : NUM_CHECKS)*(ADDR_W+DATA_W)-1:0]
    EXP_TABLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [PC_W-1:0]   pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam int EW    = ADDR_W + DATA_W;
  localparam int NC1   = (NUM_CHECKS == 0) ? 1 : NUM_CHECKS;
  localparam int IDX_W = (NC1 > 1) ? $clog2(NC1) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_TOUT = 2'd1;
  localparam logic [1:0] FC_PC   = 2'd2;
  localparam logic [1:0] FC_DATA = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHK_PC,
    S_RD,
    S_CMP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_pass;
  logic [1:0]        r_fail_code;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  state_t            w_state;
  logic [CNT_W-1:0]  w_cnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mem_rd;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_pass;
  logic [1:0]        w_fail_code;
  logic [ADDR_W-1:0] w_fail_addr;
  logic [DATA_W-1:0] w_fail_data;

  logic [ADDR_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_cur_data;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [DATA_W-1:0] w_pc_ext;
  logic              w_last;
  logic              w_tout;

  // Table entry under comparison and the address of the one after it
  always_comb begin
    w_cur_addr = EXP_TABLE[int'(r_idx)*EW + DATA_W +: ADDR_W];
    w_cur_data = EXP_TABLE[int'(r_idx)*EW +: DATA_W];
    w_nxt_addr = EXP_TABLE[(int'(r_idx) + 1)*EW + DATA_W +: ADDR_W];
    w_pc_ext   = DATA_W'(pc);
    w_last     = (r_idx == IDX_W'(NC1 - 1));
    w_tout     = (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_mem_rd    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_pass      = r_pass;
    w_fail_code = r_fail_code;
    w_fail_addr = r_fail_addr;
    w_fail_data = r_fail_data;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state     = S_RUN;
          w_cnt       = '0;
          w_idx       = '0;
          w_pass      = 1'b0;
          w_fail_code = FC_NONE;
          w_fail_addr = '0;
          w_fail_data = '0;
        end
      end
      S_RUN: begin
        if (r_cnt != {CNT_W{1'b1}}) w_cnt = r_cnt + 1'b1;
        if (halt) begin
          w_state = S_CHK_PC;
        end else if (w_tout) begin
          w_state     = S_DONE;
          w_fail_code = FC_TOUT;
        end
      end
      S_CHK_PC: begin
        if (pc != HALT_PC) begin
          w_state     = S_DONE;
          w_fail_code = FC_PC;
          w_fail_data = w_pc_ext;
        end else if (NUM_CHECKS == 0) begin
          w_state = S_DONE;
          w_pass  = 1'b1;
        end else begin
          w_state    = S_RD;
          w_mem_rd   = 1'b1;
          w_mem_addr = w_cur_addr;
        end
      end
      S_RD: begin
        w_state = S_CMP;
      end
      S_CMP: begin
        if (mem_rdata != w_cur_data) begin
          w_state     = S_DONE;
          w_fail_code = FC_DATA;
          w_fail_addr = w_cur_addr;
          w_fail_data = mem_rdata;
        end else if (w_last) begin
          w_state = S_DONE;
          w_pass  = 1'b1;
        end else begin
          w_state    = S_RD;
          w_idx      = r_idx + 1'b1;
          w_mem_rd   = 1'b1;
          w_mem_addr = w_nxt_addr;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_pass      <= 1'b0;
      r_fail_code <= FC_NONE;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_mem_rd    <= w_mem_rd;
      r_mem_addr  <= w_mem_addr;
      r_pass      <= w_pass;
      r_fail_code <= w_fail_code;
      r_fail_addr <= w_fail_addr;
      r_fail_data <= w_fail_data;
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign busy      = (r_state == S_RUN) || (r_state == S_CHK_PC) ||
                     (r_state == S_RD)  || (r_state == S_CMP);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule
